// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: double-buffered left/right pairs serialized MSB-first on sd,
// ws leading data by one slot. All state advances on the falling edge of sck.
module i2s_tx_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] left_data,
  input  logic [WORD_WIDTH-1:0] right_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  underrun_clr,
  output logic                  sd,
  output logic                  ws,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int unsigned W          = WORD_WIDTH;
  localparam int unsigned FRAME_BITS = 2 * W;
  localparam int unsigned SLOT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_BITS - 1);
  localparam logic [SLOT_W-1:0] WS_RISE   = SLOT_W'(W - 1);
  localparam logic [SLOT_W-1:0] WS_FALL   = SLOT_W'(2 * W - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [SLOT_W-1:0]       slot, slot_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic [W-1:0]            hold_left, hold_left_n;
  logic [W-1:0]            hold_right, hold_right_n;
  logic                    hold_full, hold_full_n;
  logic                    underrun_n;
  logic                    frame_start_n;
  logic                    ws_n;
  logic                    load_ready_n;
  logic                    transfer;
  logic                    underrun_set;

  assign sd = shreg[FRAME_BITS-1];

  // Next-state, datapath and output decode
  always_comb begin
    state_n       = state;
    slot_n        = slot;
    shreg_n       = {shreg[FRAME_BITS-2:0], 1'b0};
    hold_left_n   = hold_left;
    hold_right_n  = hold_right;
    hold_full_n   = hold_full;
    frame_start_n = 1'b0;
    ws_n          = 1'b0;
    load_ready_n  = 1'b1;
    transfer      = 1'b0;
    underrun_set  = 1'b0;
    underrun_n    = underrun & ~underrun_clr;

    case (state)
      IDLE: begin
        slot_n  = '0;
        shreg_n = '0;
        if (en && hold_full) begin
          state_n       = RUN;
          shreg_n       = {hold_left, hold_right};
          transfer      = 1'b1;
          frame_start_n = 1'b1;
        end
      end
      RUN: begin
        if (slot == LAST_SLOT) begin
          // Frame boundary: en only matters here, so a started frame always completes
          slot_n = '0;
          if (!en) begin
            state_n = IDLE;
            shreg_n = '0;
          end else if (hold_full) begin
            shreg_n       = {hold_left, hold_right};
            transfer      = 1'b1;
            frame_start_n = 1'b1;
          end else begin
            shreg_n       = '0;
            underrun_set  = 1'b1;
            frame_start_n = 1'b1;
          end
        end else begin
          slot_n = slot + SLOT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        slot_n  = '0;
        shreg_n = '0;
      end
    endcase

    // Transfer and accept are mutually exclusive: accept needs an empty buffer
    if (transfer) begin
      hold_full_n = 1'b0;
    end else if (load_valid && !hold_full) begin
      hold_left_n  = left_data;
      hold_right_n = right_data;
      hold_full_n  = 1'b1;
    end

    if (underrun_set) begin
      underrun_n = 1'b1;
    end

    ws_n         = (state_n == RUN) && (slot_n >= WS_RISE) && (slot_n <= WS_FALL);
    load_ready_n = ~hold_full_n;
  end

  // State and output registers
  always_ff @(negedge sck or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      shreg       <= '0;
      hold_left   <= '0;
      hold_right  <= '0;
      hold_full   <= 1'b0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
      ws          <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      shreg       <= shreg_n;
      hold_left   <= hold_left_n;
      hold_right  <= hold_right_n;
      hold_full   <= hold_full_n;
      underrun    <= underrun_n;
      frame_start <= frame_start_n;
      ws          <= ws_n;
      load_ready  <= load_ready_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: directed frame table, corner-case sequences,
// and randomized traffic against a frame-position reference model.
module tb_i2s_tx_serializer;

  localparam int unsigned W = 8;

  logic         sck;
  logic         rst;
  logic         en;
  logic [W-1:0] left_data;
  logic [W-1:0] right_data;
  logic         load_valid;
  logic         load_ready;
  logic         underrun_clr;
  logic         sd;
  logic         ws;
  logic         frame_start;
  logic         underrun;

  int checks = 0;
  int errors = 0;

  i2s_tx_serializer #(.WORD_WIDTH(W)) dut (
    .sck(sck), .rst(rst), .en(en),
    .left_data(left_data), .right_data(right_data),
    .load_valid(load_valid), .load_ready(load_ready),
    .underrun_clr(underrun_clr),
    .sd(sd), .ws(ws), .frame_start(frame_start), .underrun(underrun)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // Reference model: frame position (-1 = idle), current pair, pending-pair queue
  int              m_pos;
  logic [2*W-1:0]  m_cur;
  logic [2*W-1:0]  m_q[$];
  logic            m_ur;
  bit              m_was_empty;
  bit              m_set;

  always @(posedge rst or negedge sck) begin
    if (rst) begin
      m_pos = -1;
      m_cur = '0;
      m_q.delete();
      m_ur  = 1'b0;
    end else begin
      m_was_empty = (m_q.size() == 0);
      m_set       = 1'b0;
      if (m_pos == -1 || m_pos == 2*W-1) begin
        if (m_pos != -1 && !en) begin
          m_pos = -1;
        end else if (en && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end else if (m_pos != -1) begin
          m_cur = '0;
          m_pos = 0;
          m_set = 1'b1;
        end
      end else begin
        m_pos++;
      end
      if (m_was_empty && load_valid) m_q.push_back({left_data, right_data});
      m_ur = m_set | (m_ur & ~underrun_clr);
    end
  end

  always @(posedge sck) begin
    if (!rst) begin
      chk("model_sd", sd, (m_pos < 0) ? 1'b0 : m_cur[2*W-1-m_pos]);
      chk("model_ws", ws, (m_pos >= int'(W) - 1) && (m_pos <= 2*int'(W) - 2));
      chk("model_frame_start", frame_start, m_pos == 0);
      chk("model_load_ready", load_ready, m_q.size() == 0);
      chk("model_underrun", underrun, m_ur);
    end
  end

  typedef struct {
    logic [W-1:0]   l;
    logic [W-1:0]   r;
    logic [2*W-1:0] sd_exp;
    logic [2*W-1:0] ws_exp;
  } vec_t;

  vec_t vecs [4];

  // Load one pair from idle, send exactly one frame, return to idle
  task automatic run_vec(input vec_t v);
    logic [15:0] sdb, wsb, fsb;
    left_data = v.l; right_data = v.r; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      sdb[15-k] = sd; wsb[15-k] = ws; fsb[15-k] = frame_start;
      if (k == 0) en = 1'b0;
      tick();
    end
    chk("vec_sd", sdb, v.sd_exp);
    chk("vec_ws", wsb, v.ws_exp);
    chk("vec_frame_start", fsb, 16'h8000);
    chk("vec_idle_sd", sd, 1'b0);
    chk("vec_idle_ws", ws, 1'b0);
  endtask

  task automatic back_to_back();
    logic [31:0] bits;
    left_data = 8'hFF; right_data = 8'h00; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 33; k++) begin
      if (k < 32) bits[31-k] = sd;
      if (k == 0) begin
        chk("b2b_ready_slot0", load_ready, 1'b1);
        left_data = 8'h01; right_data = 8'h80; load_valid = 1'b1;
      end
      if (k == 1) begin
        chk("b2b_ready_low", load_ready, 1'b0);
        load_valid = 1'b0;
      end
      if (k == 15) chk("b2b_ready_before_xfer", load_ready, 1'b0);
      if (k == 16) begin
        chk("b2b_no_gap_fs", frame_start, 1'b1);
        chk("b2b_ready_after_xfer", load_ready, 1'b1);
      end
      if (k == 17) en = 1'b0;
      if (k == 32) chk("b2b_idle_sd", sd, 1'b0);
      if (k < 32) tick();
    end
    chk("b2b_sd", bits, 32'hFF00_0180);
  endtask

  task automatic underrun_seq();
    logic [47:0] sdb, wsb;
    left_data = 8'h12; right_data = 8'h34; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 48; k++) begin
      sdb[47-k] = sd; wsb[47-k] = ws;
      if (k == 15) chk("ur_before", underrun, 1'b0);
      if (k == 16) chk("ur_set", underrun, 1'b1);
      if (k == 20) underrun_clr = 1'b1;
      if (k == 21) begin
        chk("ur_cleared", underrun, 1'b0);
        underrun_clr = 1'b0;
      end
      if (k == 31) underrun_clr = 1'b1;
      if (k == 32) begin
        chk("ur_set_wins", underrun, 1'b1);
        underrun_clr = 1'b0;
        en = 1'b0;
      end
      tick();
    end
    chk("ur_sd", sdb, 48'h1234_0000_0000);
    chk("ur_ws", wsb, 48'h01FE_01FE_01FE);
    chk("ur_sticky_idle", underrun, 1'b1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("ur_clr_idle", underrun, 1'b0);
  endtask

  task automatic stop_seq();
    logic [15:0] b;
    left_data = 8'hAA; right_data = 8'h55; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      b[15-k] = sd;
      if (k == 2) begin
        left_data = 8'h0F; right_data = 8'hF0; load_valid = 1'b1;
      end
      if (k == 3) load_valid = 1'b0;
      if (k == 4) en = 1'b0;
      tick();
    end
    chk("stop_full_frame", b, 16'hAA55);
    for (int j = 0; j < 4; j++) begin
      chk("stop_idle_sd", sd, 1'b0);
      chk("stop_idle_ws", ws, 1'b0);
      chk("stop_pending_ready", load_ready, 1'b0);
      tick();
    end
    en = 1'b1;
    tick();
    chk("stop_restart_fs", frame_start, 1'b1);
    for (int k = 0; k < 16; k++) begin
      b[15-k] = sd;
      if (k == 0) en = 1'b0;
      tick();
    end
    chk("stop_pending_sent", b, 16'h0FF0);
    chk("stop_ready_after", load_ready, 1'b1);
  endtask

  task automatic backpressure_seq();
    logic [15:0] b;
    en = 1'b0; left_data = 8'h11; right_data = 8'h22; load_valid = 1'b1;
    tick();
    left_data = 8'h99; right_data = 8'h88;
    for (int j = 0; j < 4; j++) begin
      chk("bp_ready_low", load_ready, 1'b0);
      tick();
    end
    load_valid = 1'b0; en = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      b[15-k] = sd;
      if (k == 0) en = 1'b0;
      tick();
    end
    chk("bp_original_data", b, 16'h1122);
  endtask

  task automatic reset_mid_frame();
    left_data = 8'hC3; right_data = 8'h5A; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 40; k++) begin
      if (k == 18) begin
        left_data = 8'hFF; right_data = 8'hFF; load_valid = 1'b1;
      end
      if (k == 19) load_valid = 1'b0;
      if (k == 33) begin
        left_data = 8'h77; right_data = 8'h66; load_valid = 1'b1;
      end
      if (k == 34) load_valid = 1'b0;
      tick();
    end
    chk("rst_pre_sd", sd, 1'b1);
    chk("rst_pre_ws", ws, 1'b1);
    chk("rst_pre_ready", load_ready, 1'b0);
    chk("rst_pre_underrun", underrun, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_sd", sd, 1'b0);
    chk("rst_async_ws", ws, 1'b0);
    chk("rst_async_ready", load_ready, 1'b1);
    chk("rst_async_underrun", underrun, 1'b0);
    chk("rst_async_fs", frame_start, 1'b0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; underrun_clr = 1'b0;
    left_data = '0; right_data = '0;

    vecs[0] = '{l: 8'hA5, r: 8'h3C, sd_exp: 16'hA53C, ws_exp: 16'h01FE};
    vecs[1] = '{l: 8'hFF, r: 8'h00, sd_exp: 16'hFF00, ws_exp: 16'h01FE};
    vecs[2] = '{l: 8'h01, r: 8'h80, sd_exp: 16'h0180, ws_exp: 16'h01FE};
    vecs[3] = '{l: 8'h00, r: 8'hFF, sd_exp: 16'h00FF, ws_exp: 16'h01FE};

    #3;
    chk("reset_sd", sd, 1'b0);
    chk("reset_ws", ws, 1'b0);
    chk("reset_ready", load_ready, 1'b1);
    chk("reset_fs", frame_start, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    back_to_back();
    underrun_seq();
    stop_seq();
    backpressure_seq();
    reset_mid_frame();
    run_vec(vecs[0]);

    for (int n = 0; n < 3000; n++) begin
      en           = ($urandom_range(0, 15) != 0);
      load_valid   = $urandom_range(0, 1) == 1;
      left_data    = W'($urandom);
      right_data   = W'($urandom);
      underrun_clr = ($urandom_range(0, 15) == 0);
      if (n == 1500) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    en = 1'b0; load_valid = 1'b0; underrun_clr = 1'b0;
    repeat (40) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
